syncfifo_param: RTL and testbench

Parametrised single-clock FIFO, successor to the fixed 32-bit synchronous FIFO used between SwitchMCU datapath stages. It adds configurable data width and depth, an occupancy count, programmable almost-full/almost-empty thresholds, and single-cycle overflow/underflow error pulses. First-word-fall-through read mode is a compile-time option.

---
 rtl/syncfifo_param_if.sv | 30 +++
 rtl/syncfifo_param.sv | 83 ++++++++
 tb/tb_syncfifo_param.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/syncfifo_param_if.sv
// Handshake bundle for syncfifo_param: write side, read side,
// occupancy and status flags.
interface syncfifo_param_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
);
    logic                     wen;
    logic [DATA_W-1:0]        wdata;
    logic                     full;
    logic                     almost_full;
    logic                     ren;
    logic [DATA_W-1:0]        rdata;
    logic                     empty;
    logic                     almost_empty;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;
    logic                     underflow;

    modport master (
        output wen, wdata, ren,
        input  full, almost_full, rdata, empty, almost_empty,
        input  count, overflow, underflow
    );

    modport slave (
        input  wen, wdata, ren,
        output full, almost_full, rdata, empty, almost_empty,
        output count, overflow, underflow
    );
endinterface

// File: rtl/syncfifo_param.sv
// Parametrised single-clock FIFO with count, thresholds and error pulses.
// Define SYNCFIFO_FWFT_EN for first-word-fall-through reads.
module syncfifo_param #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic              clk,
    input  logic              rstn,
    syncfifo_param_if.slave   fifo
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     count_w;
    logic              full_w, empty_w;
    logic              wr_acc, rd_acc;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    // Wrap bit makes the modulo difference distinguish full from empty
    assign count_w = wr_ptr_q - rd_ptr_q;
    assign full_w  = (count_w == PW'(DEPTH));
    assign empty_w = (count_w == '0);

    assign wr_acc = fifo.wen && !full_w;
    assign rd_acc = fifo.ren && !empty_w;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = fifo.wen && full_w;
        underflow_d = fifo.ren && empty_w;
        if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
        if (rd_acc) rd_ptr_d = rd_ptr_q + PW'(1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q[AW-1:0]] <= fifo.wdata;
    end

`ifdef SYNCFIFO_FWFT_EN
    assign fifo.rdata = mem_q[rd_ptr_q[AW-1:0]];
`else
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata_q <= '0;
        end else if (rd_acc) begin
            rdata_q <= mem_q[rd_ptr_q[AW-1:0]];
        end
    end

    assign fifo.rdata = rdata_q;
`endif

    assign fifo.count        = count_w;
    assign fifo.full         = full_w;
    assign fifo.empty        = empty_w;
    assign fifo.almost_full  = (count_w >= PW'(AF_LEVEL));
    assign fifo.almost_empty = (count_w <= PW'(AE_LEVEL));
    assign fifo.overflow     = overflow_q;
    assign fifo.underflow    = underflow_q;
endmodule

// File: tb/tb_syncfifo_param.sv
// Directed self-checking bench for syncfifo_param.
// DATA_W=32, DEPTH=16, AF_LEVEL=14, AE_LEVEL=2.
module tb_syncfifo_param;
    logic clk;
    logic rstn;
    int   checks;
    int   errors;
    int   q[$];

    syncfifo_param_if #(.DATA_W(32), .DEPTH(16)) bus ();

    syncfifo_param #(
        .DATA_W(32), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .fifo (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cyc();
        cyc();
        checks++;
        if (bus.count !== 5'd0) begin
            errors++;
            $display("FAIL reset_count got=%0d exp=0", bus.count);
        end
        checks++;
        if ({bus.full, bus.almost_full, bus.empty, bus.almost_empty}
            !== 4'b0011) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=0011",
                     {bus.full, bus.almost_full, bus.empty, bus.almost_empty});
        end
        checks++;
        if ({bus.overflow, bus.underflow} !== 2'b00) begin
            errors++;
            $display("FAIL reset_err got=%b exp=00",
                     {bus.overflow, bus.underflow});
        end
`ifndef SYNCFIFO_FWFT_EN
        checks++;
        if (bus.rdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_rdata got=%0h exp=0", bus.rdata);
        end
`endif
        rstn = 1'b1;
        cyc();
    endtask

    task automatic test_fill();
        logic [3:0] ef;
        for (int i = 1; i <= 16; i++) begin
            bus.wen   = 1'b1;
            bus.wdata = 32'(i);
            cyc();
            ef = {i == 16, i >= 14, 1'b0, i <= 2};
            checks++;
            if (bus.count !== 5'(i)) begin
                errors++;
                $display("FAIL fill_count got=%0d exp=%0d", bus.count, i);
            end
            checks++;
            if ({bus.full, bus.almost_full, bus.empty, bus.almost_empty,
                 bus.overflow} !== {ef, 1'b0}) begin
                errors++;
                $display("FAIL fill_flags i=%0d got=%b exp=%b", i,
                         {bus.full, bus.almost_full, bus.empty,
                          bus.almost_empty, bus.overflow}, {ef, 1'b0});
            end
        end
        bus.wdata = 32'd17;
        cyc();
        bus.wen = 1'b0;
        checks++;
        if ({bus.overflow, bus.count} !== {1'b1, 5'd16}) begin
            errors++;
            $display("FAIL overflow_pulse got=%b/%0d exp=1/16",
                     bus.overflow, bus.count);
        end
        cyc();
        checks++;
        if (bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clear got=%b exp=0", bus.overflow);
        end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 16; i++) begin
            bus.ren = 1'b1;
`ifdef SYNCFIFO_FWFT_EN
            checks++;
            if (bus.rdata !== 32'(i)) begin
                errors++;
                $display("FAIL drain_data got=%0d exp=%0d", bus.rdata, i);
            end
`endif
            cyc();
`ifndef SYNCFIFO_FWFT_EN
            checks++;
            if (bus.rdata !== 32'(i)) begin
                errors++;
                $display("FAIL drain_data got=%0d exp=%0d", bus.rdata, i);
            end
`endif
            checks++;
            if ({bus.count, bus.empty} !== {5'(16 - i), i == 16}) begin
                errors++;
                $display("FAIL drain_count i=%0d got=%0d/%b", i,
                         bus.count, bus.empty);
            end
        end
        cyc();
        bus.ren = 1'b0;
        checks++;
        if (bus.underflow !== 1'b1) begin
            errors++;
            $display("FAIL underflow_pulse got=%b exp=1", bus.underflow);
        end
`ifndef SYNCFIFO_FWFT_EN
        checks++;
        if (bus.rdata !== 32'd16) begin
            errors++;
            $display("FAIL underflow_hold got=%0d exp=16", bus.rdata);
        end
`endif
        cyc();
        checks++;
        if (bus.underflow !== 1'b0) begin
            errors++;
            $display("FAIL underflow_clear got=%b exp=0", bus.underflow);
        end
    endtask

    task automatic test_back_to_back();
        int exp;
        q.delete();
        for (int i = 0; i < 8; i++) begin
            bus.wen   = 1'b1;
            bus.wdata = 32'(100 + i);
            q.push_back(100 + i);
            cyc();
        end
        bus.ren = 1'b1;
        for (int k = 0; k < 40; k++) begin
            bus.wdata = 32'(200 + k);
`ifdef SYNCFIFO_FWFT_EN
            checks++;
            if (bus.rdata !== 32'(q[0])) begin
                errors++;
                $display("FAIL b2b_data k=%0d got=%0d exp=%0d",
                         k, bus.rdata, q[0]);
            end
`endif
            exp = q.pop_front();
            q.push_back(200 + k);
            cyc();
`ifndef SYNCFIFO_FWFT_EN
            checks++;
            if (bus.rdata !== 32'(exp)) begin
                errors++;
                $display("FAIL b2b_data k=%0d got=%0d exp=%0d",
                         k, bus.rdata, exp);
            end
`endif
            checks++;
            if ({bus.count, bus.full, bus.almost_full, bus.empty,
                 bus.almost_empty, bus.overflow, bus.underflow}
                !== {5'd8, 6'b0}) begin
                errors++;
                $display("FAIL b2b_state k=%0d count=%0d flags=%b", k,
                         bus.count, {bus.full, bus.almost_full, bus.empty,
                         bus.almost_empty, bus.overflow, bus.underflow});
            end
        end
        bus.wen = 1'b0;
        for (int i = 0; i < 8; i++) begin
`ifdef SYNCFIFO_FWFT_EN
            checks++;
            if (bus.rdata !== 32'(q[0])) begin
                errors++;
                $display("FAIL b2b_tail got=%0d exp=%0d", bus.rdata, q[0]);
            end
`endif
            exp = q.pop_front();
            cyc();
`ifndef SYNCFIFO_FWFT_EN
            checks++;
            if (bus.rdata !== 32'(exp)) begin
                errors++;
                $display("FAIL b2b_tail got=%0d exp=%0d", bus.rdata, exp);
            end
`endif
        end
        bus.ren = 1'b0;
        checks++;
        if (bus.empty !== 1'b1) begin
            errors++;
            $display("FAIL b2b_empty got=%b exp=1", bus.empty);
        end
    endtask

    task automatic test_boundary();
        bus.wen = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.wdata = 32'(300 + i);
            cyc();
        end
        bus.ren   = 1'b1;
        bus.wdata = 32'd999;
        cyc();
        bus.wen = 1'b0;
        checks++;
        if ({bus.overflow, bus.count} !== {1'b1, 5'd15}) begin
            errors++;
            $display("FAIL full_simul got=%b/%0d exp=1/15",
                     bus.overflow, bus.count);
        end
`ifndef SYNCFIFO_FWFT_EN
        checks++;
        if (bus.rdata !== 32'd300) begin
            errors++;
            $display("FAIL full_simul_data got=%0d exp=300", bus.rdata);
        end
`endif
        for (int i = 1; i < 16; i++) begin
`ifdef SYNCFIFO_FWFT_EN
            checks++;
            if (bus.rdata !== 32'(300 + i)) begin
                errors++;
                $display("FAIL full_drain got=%0d exp=%0d",
                         bus.rdata, 300 + i);
            end
`endif
            cyc();
`ifndef SYNCFIFO_FWFT_EN
            checks++;
            if (bus.rdata !== 32'(300 + i)) begin
                errors++;
                $display("FAIL full_drain got=%0d exp=%0d",
                         bus.rdata, 300 + i);
            end
`endif
        end
        bus.wen   = 1'b1;
        bus.wdata = 32'd555;
        cyc();
        bus.wen = 1'b0;
        bus.ren = 1'b0;
        checks++;
        if ({bus.underflow, bus.count, bus.empty}
            !== {1'b1, 5'd1, 1'b0}) begin
            errors++;
            $display("FAIL empty_simul got=%b/%0d/%b exp=1/1/0",
                     bus.underflow, bus.count, bus.empty);
        end
`ifndef SYNCFIFO_FWFT_EN
        checks++;
        if (bus.rdata !== 32'd315) begin
            errors++;
            $display("FAIL empty_simul_hold got=%0d exp=315", bus.rdata);
        end
`else
        checks++;
        if (bus.rdata !== 32'd555) begin
            errors++;
            $display("FAIL empty_simul_data got=%0d exp=555", bus.rdata);
        end
`endif
        bus.ren = 1'b1;
        cyc();
        bus.ren = 1'b0;
`ifndef SYNCFIFO_FWFT_EN
        checks++;
        if (bus.rdata !== 32'd555) begin
            errors++;
            $display("FAIL empty_simul_data got=%0d exp=555", bus.rdata);
        end
`endif
        checks++;
        if (bus.empty !== 1'b1) begin
            errors++;
            $display("FAIL empty_simul_pop got=%b exp=1", bus.empty);
        end
    endtask

    task automatic test_async_reset();
        bus.wen = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.wdata = 32'(40 + i);
            cyc();
        end
        bus.ren = 1'b1;
        cyc();
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (bus.count !== 5'd0) begin
            errors++;
            $display("FAIL async_count got=%0d exp=0", bus.count);
        end
        checks++;
        if ({bus.full, bus.almost_full, bus.empty, bus.almost_empty}
            !== 4'b0011) begin
            errors++;
            $display("FAIL async_flags got=%b exp=0011",
                     {bus.full, bus.almost_full, bus.empty, bus.almost_empty});
        end
`ifndef SYNCFIFO_FWFT_EN
        checks++;
        if (bus.rdata !== 32'd0) begin
            errors++;
            $display("FAIL async_rdata got=%0d exp=0", bus.rdata);
        end
`endif
        bus.wen = 1'b0;
        bus.ren = 1'b0;
        cyc();
        rstn = 1'b1;
        cyc();
    endtask

`ifdef SYNCFIFO_FWFT_EN
    task automatic test_fwft();
        bus.wen   = 1'b1;
        bus.wdata = 32'hA5;
        cyc();
        bus.wen = 1'b0;
        checks++;
        if ({bus.empty, bus.rdata} !== {1'b0, 32'hA5}) begin
            errors++;
            $display("FAIL fwft_head got=%b/%0h exp=0/a5",
                     bus.empty, bus.rdata);
        end
        bus.ren = 1'b1;
        cyc();
        bus.ren = 1'b0;
        checks++;
        if (bus.empty !== 1'b1) begin
            errors++;
            $display("FAIL fwft_pop got=%b exp=1", bus.empty);
        end
    endtask
`endif

    initial begin
        checks    = 0;
        errors    = 0;
        rstn      = 1'b0;
        bus.wen   = 1'b0;
        bus.ren   = 1'b0;
        bus.wdata = '0;
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_boundary();
        test_async_reset();
`ifdef SYNCFIFO_FWFT_EN
        test_fwft();
`endif
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
